// File: rtl/tilelink_ad_responder_if.sv
// tilelink_ad_responder_if: TileLink-UL/UH A and D channel bundle between master and responder
interface tilelink_ad_responder_if #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 1,
    parameter int SIZE_W   = 4
);
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_bits_opcode;
    logic [2:0]            a_bits_param;
    logic [SIZE_W-1:0]     a_bits_size;
    logic [SOURCE_W-1:0]   a_bits_source;
    logic [ADDR_W-1:0]     a_bits_address;
    logic [DATA_W/8-1:0]   a_bits_mask;
    logic [DATA_W-1:0]     a_bits_data;
    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_bits_opcode;
    logic [1:0]            d_bits_param;
    logic [SIZE_W-1:0]     d_bits_size;
    logic [SOURCE_W-1:0]   d_bits_source;
    logic                  d_bits_sink;
    logic [DATA_W-1:0]     d_bits_data;
    logic                  d_bits_error;

    modport master (
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, d_ready,
        input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size,
               d_bits_source, d_bits_sink, d_bits_data, d_bits_error
    );

    modport slave (
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, d_ready,
        output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size,
               d_bits_source, d_bits_sink, d_bits_data, d_bits_error
    );
endinterface

// File: rtl/tilelink_ad_responder.sv
// tilelink_ad_responder: in-order TileLink A/D memory stand-in with burst tracking and protocol checking
module tilelink_ad_responder #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 1,
    parameter int SIZE_W   = 4,
    parameter int DEPTH    = 4,
    parameter int FAST_MEM = 0,
    parameter int ERROR_EN = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    tilelink_ad_responder_if.slave   tl,
    input  logic                     delay_a_nd,
    input  logic                     delay_d_nd,
    input  logic [DATA_W-1:0]        rdata_nd,
    input  logic                     d_error_nd,
    output logic                     protocol_err,
    output logic [$clog2(DEPTH):0]   outstanding
);
    localparam int          PW    = $clog2(DEPTH);
    localparam logic [31:0] LG    = 32'($clog2(DATA_W / 8));
    localparam logic [PW:0] FULL  = (PW + 1)'(DEPTH);
    localparam logic        STALL = FAST_MEM == 0;

    function automatic logic [31:0] last_idx(input logic [SIZE_W-1:0] s);
        return (32'(s) <= LG) ? 32'd0 : (32'd1 << (32'(s) - LG)) - 32'd1;
    endfunction

    logic [2:0]          q_op   [DEPTH];
    logic [SIZE_W-1:0]   q_size [DEPTH];
    logic [SOURCE_W-1:0] q_src  [DEPTH];
    logic [PW-1:0]       head, tail;
    logic [SIZE_W-1:0]   a_cnt, d_cnt;
    logic                burst;
    logic [2:0]          b_op;
    logic [SIZE_W-1:0]   b_size;
    logic [SOURCE_W-1:0] b_src;
    logic [ADDR_W-1:0]   b_addr;
    logic                a_fire, d_fire, a_put, a_last, enq, pop;
    logic                d_multi, d_last, mismatch, misalign;
    logic [2:0]          h_op;
    logic                unused_bits;

    assign unused_bits = ^{tl.a_bits_param, tl.a_bits_mask, tl.a_bits_data};

    assign tl.a_ready = reset_n && (outstanding != FULL) && !(delay_a_nd && STALL);
    assign tl.d_valid = reset_n && (outstanding != '0) && !(delay_d_nd && STALL);
    assign a_fire     = tl.a_valid && tl.a_ready;
    assign d_fire     = tl.d_valid && tl.d_ready;

    assign a_put    = tl.a_bits_opcode[2:1] == 2'b00;
    assign a_last   = !a_put || (32'(a_cnt) == last_idx(tl.a_bits_size));
    assign enq      = a_fire && a_last;
    assign mismatch = burst && (tl.a_bits_opcode != b_op || tl.a_bits_size != b_size ||
                                tl.a_bits_source != b_src || tl.a_bits_address != b_addr);
    assign misalign = (32'(tl.a_bits_size) > LG) &&
                      ((tl.a_bits_address & ((ADDR_W'(1) << tl.a_bits_size) - ADDR_W'(1))) != '0);

    assign h_op    = q_op[head];
    assign d_multi = h_op == 3'd2 || h_op == 3'd3 || h_op == 3'd4;
    assign d_last  = !d_multi || (32'(d_cnt) == last_idx(q_size[head]));
    assign pop     = d_fire && d_last;

    // Decode the head entry into the D-channel response fields
    always_comb begin
        tl.d_bits_opcode = d_multi ? 3'd1 : (h_op == 3'd5) ? 3'd2 : 3'd0;
        tl.d_bits_error  = (h_op[2:1] == 2'b11) ? 1'b1 : (d_multi && ERROR_EN != 0) ? d_error_nd : 1'b0;
        tl.d_bits_param  = 2'd0;
        tl.d_bits_sink   = 1'b0;
        tl.d_bits_size   = q_size[head];
        tl.d_bits_source = q_src[head];
        tl.d_bits_data   = rdata_nd;
    end

    // Queue storage needs no reset: occupancy alone decides which entries are live
    always_ff @(posedge clock) begin
        if (enq) begin
            q_op[tail]   <= tl.a_bits_opcode;
            q_size[tail] <= tl.a_bits_size;
            q_src[tail]  <= tl.a_bits_source;
        end
    end

    // Pointers, occupancy, beat counters, burst capture and the sticky violation flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head         <= '0;
            tail         <= '0;
            outstanding  <= '0;
            a_cnt        <= '0;
            d_cnt        <= '0;
            burst        <= 1'b0;
            b_op         <= '0;
            b_size       <= '0;
            b_src        <= '0;
            b_addr       <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (a_fire && a_put) begin
                a_cnt <= a_last ? '0 : a_cnt + 1'b1;
                burst <= !a_last;
                if (!burst) begin
                    b_op   <= tl.a_bits_opcode;
                    b_size <= tl.a_bits_size;
                    b_src  <= tl.a_bits_source;
                    b_addr <= tl.a_bits_address;
                end
            end
            if (d_fire) d_cnt <= d_last ? '0 : d_cnt + 1'b1;
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            outstanding <= outstanding + (PW + 1)'(enq) - (PW + 1)'(pop);
            if (a_fire && (mismatch || misalign)) protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tilelink_ad_responder.sv
// tb_tilelink_ad_responder: directed vector table plus hand sequences for reset, misalignment and fast memory
module tb_tilelink_ad_responder;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        delay_a_nd, delay_d_nd, d_error_nd;
    logic [63:0] rdata_nd;
    logic        protocol_err, f_protocol_err;
    logic [2:0]  outstanding, f_outstanding;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    tilelink_ad_responder_if bus ();
    tilelink_ad_responder_if fbus ();

    tilelink_ad_responder dut (
        .clock(clock), .reset_n(reset_n), .tl(bus),
        .delay_a_nd(delay_a_nd), .delay_d_nd(delay_d_nd),
        .rdata_nd(rdata_nd), .d_error_nd(d_error_nd),
        .protocol_err(protocol_err), .outstanding(outstanding)
    );

    tilelink_ad_responder #(.FAST_MEM(1)) fast (
        .clock(clock), .reset_n(reset_n), .tl(fbus),
        .delay_a_nd(delay_a_nd), .delay_d_nd(delay_d_nd),
        .rdata_nd(rdata_nd), .d_error_nd(d_error_nd),
        .protocol_err(f_protocol_err), .outstanding(f_outstanding)
    );

    typedef struct {
        logic        av;
        logic [2:0]  op;
        logic [3:0]  sz;
        logic        src;
        logic [31:0] addr;
        logic        dr, dld, den;
        logic        ar, dv;
        logic [2:0]  dop;
        logic [3:0]  dsz;
        logic        dsrc, derr;
        logic [2:0]  out;
        logic        perr, cd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic av, input logic [2:0] op, input logic [3:0] sz,
                               input logic src, input logic [31:0] addr,
                               input logic dr, input logic dld, input logic den,
                               input logic ar, input logic dv, input logic [2:0] dop,
                               input logic [3:0] dsz, input logic dsrc, input logic derr,
                               input logic [2:0] out, input logic perr, input logic cd);
        vec_t t;
        t.av = av; t.op = op; t.sz = sz; t.src = src; t.addr = addr;
        t.dr = dr; t.dld = dld; t.den = den;
        t.ar = ar; t.dv = dv; t.dop = dop; t.dsz = dsz; t.dsrc = dsrc; t.derr = derr;
        t.out = out; t.perr = perr; t.cd = cd;
        return t;
    endfunction

    function automatic vec_t idle(input logic [2:0] out, input logic perr);
        return v(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, out, perr, 0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input logic av, input logic [2:0] op, input logic [3:0] sz,
                           input logic src, input logic [31:0] addr);
        bus.a_valid = av; bus.a_bits_opcode = op; bus.a_bits_size = sz;
        bus.a_bits_source = src; bus.a_bits_address = addr;
    endtask

    initial begin
        logic [63:0] exp_data;
        reset_n = 1'b0;
        delay_a_nd = 1'b0; delay_d_nd = 1'b0; d_error_nd = 1'b0; rdata_nd = '0;
        drive_a(1, 4, 3, 0, 0);
        bus.a_bits_param = '0; bus.a_bits_mask = '1; bus.a_bits_data = '0; bus.d_ready = 1'b0;
        fbus.a_valid = 1'b0; fbus.a_bits_opcode = '0; fbus.a_bits_param = '0; fbus.a_bits_size = '0;
        fbus.a_bits_source = '0; fbus.a_bits_address = '0; fbus.a_bits_mask = '1;
        fbus.a_bits_data = '0; fbus.d_ready = 1'b0;

        // multi-beat Get, size 5 over 64-bit data = 4 beats; error input ignored with ERROR_EN=0
        tv.push_back(v(1, 4, 5, 1, 'h100, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 5, 1, 0, 1, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 5, 1, 0, 1, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 5, 1, 0, 1, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 5, 1, 0, 1, 0, 1));
        tv.push_back(idle(0, 0));
        // Get with a 3-cycle D stall after the first beat
        tv.push_back(v(1, 4, 5, 0, 'h40, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 5, 0, 0, 1, 0, 1));
        for (int k = 0; k < 3; k++) tv.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++) tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 5, 0, 0, 1, 0, 1));
        tv.push_back(idle(0, 0));
        // PutFull size 4 = 2 A beats, single AccessAck
        tv.push_back(v(1, 0, 4, 0, 'h200, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 4, 0, 'h200, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 4, 0, 0, 1, 0, 1));
        tv.push_back(idle(0, 0));
        // Intent -> HintAck
        tv.push_back(v(1, 5, 3, 1, 'h8, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 3, 1, 0, 1, 0, 1));
        tv.push_back(idle(0, 0));
        // opcode 7 -> AccessAck with error
        tv.push_back(v(1, 7, 3, 0, 'h0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 3, 0, 1, 1, 0, 1));
        tv.push_back(idle(0, 0));
        // fill the queue with d_ready low, then drain in order
        tv.push_back(v(1, 4, 3, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(1, 4, 3, 1, 'h08, 0, 0, 0, 1, 1, 1, 3, 0, 0, 1, 0, 1));
        tv.push_back(v(1, 4, 3, 0, 'h10, 0, 0, 0, 1, 1, 1, 3, 0, 0, 2, 0, 1));
        tv.push_back(v(1, 4, 3, 1, 'h18, 0, 0, 0, 1, 1, 1, 3, 0, 0, 3, 0, 1));
        tv.push_back(v(1, 4, 3, 0, 'h20, 0, 0, 0, 0, 1, 1, 3, 0, 0, 4, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 3, 0, 0, 4, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 3, 1, 0, 3, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 3, 0, 0, 2, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 3, 1, 0, 1, 0, 1));
        tv.push_back(idle(0, 0));
        // PutPartial burst whose source changes on beat 2 -> sticky protocol_err
        tv.push_back(v(1, 1, 4, 0, 'h300, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(1, 1, 4, 1, 'h300, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0));
        tv.push_back(idle(0, 1));
        tv.push_back(idle(0, 1));

        // reset holds the A channel stalled even with a_valid high
        #12;
        chk("rst.a_ready", bus.a_ready, 0);
        chk("rst.d_valid", bus.d_valid, 0);
        chk("rst.outstanding", outstanding, 0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.a_valid = 1'b0;
        #1;
        chk("rel.a_ready", bus.a_ready, 1);

        foreach (tv[k]) begin
            @(negedge clock);
            drive_a(tv[k].av, tv[k].op, tv[k].sz, tv[k].src, tv[k].addr);
            bus.d_ready = tv[k].dr;
            delay_d_nd  = tv[k].dld;
            d_error_nd  = tv[k].den;
            exp_data    = {32'hDA7A0000, 32'(k)};
            rdata_nd    = exp_data;
            #1;
            chk($sformatf("v%0d.a_ready", k), bus.a_ready, tv[k].ar);
            chk($sformatf("v%0d.d_valid", k), bus.d_valid, tv[k].dv);
            chk($sformatf("v%0d.outstanding", k), outstanding, tv[k].out);
            chk($sformatf("v%0d.protocol_err", k), protocol_err, tv[k].perr);
            if (tv[k].cd) begin
                chk($sformatf("v%0d.d_opcode", k), bus.d_bits_opcode, tv[k].dop);
                chk($sformatf("v%0d.d_size", k), bus.d_bits_size, tv[k].dsz);
                chk($sformatf("v%0d.d_source", k), bus.d_bits_source, tv[k].dsrc);
                chk($sformatf("v%0d.d_error", k), bus.d_bits_error, tv[k].derr);
                chk($sformatf("v%0d.d_data", k), bus.d_bits_data, exp_data);
            end
        end

        // asynchronous reset in the middle of a Get burst
        @(negedge clock);
        drive_a(1, 4, 5, 1, 'h0);
        bus.d_ready = 1'b1; delay_d_nd = 1'b0; d_error_nd = 1'b0;
        @(negedge clock);
        bus.a_valid = 1'b0;
        #1;
        chk("midrst.pre_d_valid", bus.d_valid, 1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst.d_valid", bus.d_valid, 0);
        chk("midrst.a_ready", bus.a_ready, 0);
        chk("midrst.outstanding", outstanding, 0);
        chk("midrst.protocol_err", protocol_err, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // size-5 Get at an address not aligned to 32 bytes
        @(negedge clock);
        drive_a(1, 4, 5, 0, 'h108);
        @(negedge clock);
        bus.a_valid = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        chk("misalign.protocol_err", protocol_err, 1);
        chk("misalign.outstanding", outstanding, 0);

        // FAST_MEM ignores both stall inputs; the default instance honours them
        @(negedge clock);
        delay_a_nd = 1'b1; delay_d_nd = 1'b1;
        fbus.a_valid = 1'b1; fbus.a_bits_opcode = 3'd4; fbus.a_bits_size = 4'd5;
        fbus.a_bits_source = 1'b1; fbus.a_bits_address = '0; fbus.d_ready = 1'b1;
        #1;
        chk("fast.a_ready", fbus.a_ready, 1);
        chk("slow.a_ready_stalled", bus.a_ready, 0);
        @(negedge clock);
        fbus.a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clock);
            #1;
            chk($sformatf("fast.beat%0d.d_valid", k), fbus.d_valid, 1);
            chk($sformatf("fast.beat%0d.d_opcode", k), fbus.d_bits_opcode, 1);
        end
        @(negedge clock);
        #1;
        chk("fast.outstanding", f_outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
